// File: rtl/uart_cmd_pkg.sv
// Shared types and ASCII constants for the UART GPIO command controller.
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_CH   = 3'd1,
    ST_GET_VAL  = 3'd2,
    ST_GET_END  = 3'd3,
    ST_SEND_ACK = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    OP_CLR = 2'd0,
    OP_SET = 2'd1,
    OP_TOG = 2'd2
  } op_e;

  localparam logic [7:0] CH_START   = 8'h53;  // 'S'
  localparam logic [7:0] ACK_OK     = 8'h4B;  // 'K'
  localparam logic [7:0] ACK_ERR    = 8'h45;  // 'E'
  localparam logic [7:0] VAL_TOG    = 8'h54;  // 'T'
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_ONE  = 8'h31;

  function automatic logic is_val_byte(input logic [7:0] b);
    return (b == ASCII_ZERO) || (b == ASCII_ONE) || (b == VAL_TOG);
  endfunction

  function automatic op_e val_to_op(input logic [7:0] b);
    if (b == ASCII_ZERO) return OP_CLR;
    if (b == ASCII_ONE)  return OP_SET;
    return OP_TOG;
  endfunction

endpackage

// File: rtl/uart_cmd_if.sv
// Byte stream in, ack byte out, GPIO levels and error pulse of the command controller.
interface uart_cmd_if #(
  parameter int NUM_CH = 8
);
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic [NUM_CH-1:0] gpio_out;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              frame_err;

  modport master (
    output rx_data, rx_ready, tx_ready,
    input  gpio_out, tx_data, tx_valid, frame_err
  );

  modport slave (
    input  rx_data, rx_ready, tx_ready,
    output gpio_out, tx_data, tx_valid, frame_err
  );
endinterface

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter: expired rises once TIMEOUT_CYCLES cycles have passed since the last clear.
module uart_cmd_timer #(
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] r_count;

  // The count is 0 in the cycle after the clearing edge, so expiry lands exactly TIMEOUT_CYCLES edges later.
  assign expired = run && (r_count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear || !run) begin
      r_count <= '0;
    end else if (!expired) begin
      r_count <= r_count + 1'b1;
    end
  end
endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART "S<ch><val><LF|CR>" command parser driving registered GPIO with 'K'/'E' acks.
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int NUM_CH         = 8,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input logic      clk,
  input logic      rst,
  uart_cmd_if.slave bus
);
  localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

  if (NUM_CH < 1 || NUM_CH > 10 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("uart_cmd_ctrl: NUM_CH must be 1..10 and TIMEOUT_CYCLES >= 2");
  end

  state_e            r_state;
  op_e               r_op;
  logic [3:0]        r_ch;
  logic [NUM_CH-1:0] r_gpio;
  logic [7:0]        r_tx_data;
  logic              r_tx_valid;
  logic              r_frame_err;

  state_e            w_next;
  logic              w_ok;
  logic              w_err;
  logic              w_latch_ch;
  logic              w_latch_op;
  logic              w_expired;
  logic [7:0]        w_ch_off;
  logic              w_is_start;
  logic [NUM_CH-1:0] w_mask;
  logic [NUM_CH-1:0] w_gpio_next;

`ifdef UART_CMD_TIMEOUT_EN
  logic w_run;
  assign w_run = (r_state == ST_GET_CH) || (r_state == ST_GET_VAL) || (r_state == ST_GET_END);

  uart_cmd_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (bus.rx_ready),
    .run     (w_run),
    .expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  // Unsigned offset: bytes below '0' wrap to large values and fail the range check.
  assign w_ch_off   = bus.rx_data - ASCII_ZERO;
  assign w_is_start = (bus.rx_data == CH_START);
  assign w_mask     = ONE_HOT0 << r_ch;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next     = r_state;
    w_ok       = 1'b0;
    w_err      = 1'b0;
    w_latch_ch = 1'b0;
    w_latch_op = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.rx_ready && w_is_start) w_next = ST_GET_CH;
      end
      ST_GET_CH: begin
        if (bus.rx_ready) begin
          if (w_is_start) w_next = ST_GET_CH;
          else if (w_ch_off < 8'(NUM_CH)) begin
            w_next     = ST_GET_VAL;
            w_latch_ch = 1'b1;
          end else w_err = 1'b1;
        end else if (w_expired) w_err = 1'b1;
      end
      ST_GET_VAL: begin
        if (bus.rx_ready) begin
          if (w_is_start) w_next = ST_GET_CH;
          else if (is_val_byte(bus.rx_data)) begin
            w_next     = ST_GET_END;
            w_latch_op = 1'b1;
          end else w_err = 1'b1;
        end else if (w_expired) w_err = 1'b1;
      end
      ST_GET_END: begin
        if (bus.rx_ready) begin
          if (w_is_start) w_next = ST_GET_CH;
          else if (bus.rx_data == ASCII_LF || bus.rx_data == ASCII_CR) w_ok = 1'b1;
          else w_err = 1'b1;
        end else if (w_expired) w_err = 1'b1;
      end
      ST_SEND_ACK: begin
        if (r_tx_valid && bus.tx_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (w_ok || w_err) w_next = ST_SEND_ACK;
  end

  always_comb begin
    w_gpio_next = r_gpio;
    case (r_op)
      OP_CLR:  w_gpio_next = r_gpio & ~w_mask;
      OP_SET:  w_gpio_next = r_gpio | w_mask;
      default: w_gpio_next = r_gpio ^ w_mask;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_gpio      <= '0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
      r_frame_err <= 1'b0;
      // NOTE: frame scratch registers are reset too; they are tiny and this keeps sim free of X.
      r_ch        <= '0;
      r_op        <= OP_CLR;
    end else begin
      r_state     <= w_next;
      r_frame_err <= w_err;
      if (w_latch_ch) r_ch <= w_ch_off[3:0];
      if (w_latch_op) r_op <= val_to_op(bus.rx_data);
      if (w_ok) r_gpio <= w_gpio_next;
      if (w_ok || w_err) begin
        r_tx_valid <= 1'b1;
        r_tx_data  <= w_ok ? ACK_OK : ACK_ERR;
      end else if (r_tx_valid && bus.tx_ready) begin
        r_tx_valid <= 1'b0;
      end
    end
  end

  assign bus.gpio_out  = r_gpio;
  assign bus.tx_data   = r_tx_data;
  assign bus.tx_valid  = r_tx_valid;
  assign bus.frame_err = r_frame_err;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: frame table plus hand-written backpressure, reset and timeout sequences.
module tb_uart_cmd_ctrl;
  import uart_cmd_pkg::*;

  localparam int NUM_CH         = 8;
  localparam int TIMEOUT_CYCLES = 100;

  logic clk = 1'b0;
  logic rst;

  uart_cmd_if #(.NUM_CH(NUM_CH)) bus ();

  uart_cmd_ctrl #(.NUM_CH(NUM_CH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string             name;
    string             stim;
    logic              exp_valid;
    logic [7:0]        exp_data;
    logic              exp_fe;
    logic [NUM_CH-1:0] exp_gpio;
  } vec_t;

  vec_t vecs[17];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_ready = 1'b1;
    tick();
    bus.rx_ready = 1'b0;
    bus.rx_data  = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d,
                           input logic fe, input logic [NUM_CH-1:0] g);
    check({tag, ".gpio"}, 32'(bus.gpio_out), 32'(g));
    check({tag, ".tx_valid"}, 32'(bus.tx_valid), 32'(v));
    check({tag, ".frame_err"}, 32'(bus.frame_err), 32'(fe));
    if (v) check({tag, ".tx_data"}, 32'(bus.tx_data), 32'(d));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs = '{
      '{"set3",      "S31\n",        1'b1, ACK_OK,  1'b0, 8'h08},
      '{"tog3_cr",   "S3T\r",        1'b1, ACK_OK,  1'b0, 8'h00},
      '{"tog3_lf",   "S3T\n",        1'b1, ACK_OK,  1'b0, 8'h08},
      '{"bad_ch9",   "S9",           1'b1, ACK_ERR, 1'b1, 8'h08},
      '{"tail_idle", "1\n",          1'b0, 8'h00,   1'b0, 8'h08},
      '{"clr7",      "S70\n",        1'b1, ACK_OK,  1'b0, 8'h08},
      '{"set7",      "S71\n",        1'b1, ACK_OK,  1'b0, 8'h88},
      '{"set0_cr",   "S01\r",        1'b1, ACK_OK,  1'b0, 8'h89},
      '{"bad_ch8",   "S8",           1'b1, ACK_ERR, 1'b1, 8'h89},
      '{"bad_ch_lo", "S/",           1'b1, ACK_ERR, 1'b1, 8'h89},
      '{"bad_val",   "S2X",          1'b1, ACK_ERR, 1'b1, 8'h89},
      '{"bad_term",  "S21A",         1'b1, ACK_ERR, 1'b1, 8'h89},
      '{"restart_v", "S1S21\n",      1'b1, ACK_OK,  1'b0, 8'h8D},
      '{"restart_e", "S0TS00\n",     1'b1, ACK_OK,  1'b0, 8'h8C},
      '{"idle_junk", "xyS1T\n",      1'b1, ACK_OK,  1'b0, 8'h8E},
      '{"bad_ch_T",  "ST",           1'b1, ACK_ERR, 1'b1, 8'h8E},
      '{"tog6",      "S6T\n",        1'b1, ACK_OK,  1'b0, 8'hCE}
    };

    rst          = 1'b1;
    bus.rx_data  = 8'h00;
    bus.rx_ready = 1'b0;
    bus.tx_ready = 1'b0;
    repeat (3) tick();
    check("reset.gpio", 32'(bus.gpio_out), 32'h0);
    check("reset.tx_valid", 32'(bus.tx_valid), 32'h0);
    check("reset.tx_data", 32'(bus.tx_data), 32'h0);
    check("reset.frame_err", 32'(bus.frame_err), 32'h0);
    rst = 1'b0;

    // Table: one frame per entry, acks taken immediately.
    bus.tx_ready = 1'b1;
    foreach (vecs[i]) begin
      send_str(vecs[i].stim);
      check_out(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_fe, vecs[i].exp_gpio);
      if (vecs[i].exp_valid) begin
        tick();
        check({vecs[i].name, ".ack_done"}, 32'(bus.tx_valid), 32'h0);
        check({vecs[i].name, ".fe_single"}, 32'(bus.frame_err), 32'h0);
      end
    end

    // Ack held under backpressure; a whole frame arriving meanwhile is dropped.
    do_reset();
    bus.tx_ready = 1'b0;
    send_str("S51\n");
    check_out("hold.first", 1'b1, ACK_OK, 1'b0, 8'h20);
    begin
      string junk;
      junk = "S61\n";
      for (int k = 0; k < 20; k++) begin
        if (k < 4) begin
          bus.rx_data  = junk[k];
          bus.rx_ready = 1'b1;
        end
        tick();
        bus.rx_ready = 1'b0;
        check($sformatf("hold.cyc%0d", k), {23'h0, bus.tx_valid, bus.tx_data}, {23'h0, 1'b1, ACK_OK});
      end
    end
    check("hold.gpio", 32'(bus.gpio_out), 32'h20);
    bus.tx_ready = 1'b1;
    tick();
    check("hold.release", 32'(bus.tx_valid), 32'h0);
    repeat (3) tick();
    check("hold.no_second_ack", 32'(bus.tx_valid), 32'h0);
    check("hold.gpio_final", 32'(bus.gpio_out), 32'h20);

    // Reset mid-frame, with a byte strobed on the same edge.
    send_str("S4");
    rst          = 1'b1;
    bus.rx_data  = "1";
    bus.rx_ready = 1'b1;
    tick();
    rst          = 1'b0;
    bus.rx_ready = 1'b0;
    check_out("rst_mid", 1'b0, 8'h00, 1'b0, 8'h00);
    check("rst_mid.tx_data", 32'(bus.tx_data), 32'h0);
    send_str("1\n");
    check_out("rst_mid.tail", 1'b0, 8'h00, 1'b0, 8'h00);
    send_str("S41\n");
    check_out("rst_mid.s41", 1'b1, ACK_OK, 1'b0, 8'h10);
    tick();
    check("rst_mid.ack_done", 32'(bus.tx_valid), 32'h0);

    // Reset discards a pending ack.
    bus.tx_ready = 1'b0;
    send_str("S01\n");
    check_out("rst_ack.pending", 1'b1, ACK_OK, 1'b0, 8'h11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_out("rst_ack.cleared", 1'b0, 8'h00, 1'b0, 8'h00);
    bus.tx_ready = 1'b1;
    repeat (2) tick();
    check("rst_ack.no_ack", 32'(bus.tx_valid), 32'h0);

`ifdef UART_CMD_TIMEOUT_EN
    do_reset();
    send_str("S2");
    begin
      int first;
      first = -1;
      for (int k = 1; k <= 150 && first < 0; k++) begin
        tick();
        if (bus.frame_err) first = k;
      end
      check("timeout.latency", 32'(first), 32'd100);
    end
    check_out("timeout.ack", 1'b1, ACK_ERR, 1'b1, 8'h00);
    tick();
    check("timeout.fe_single", 32'(bus.frame_err), 32'h0);
    check("timeout.ack_done", 32'(bus.tx_valid), 32'h0);
    // A byte on the expiry edge wins over the timeout.
    send_str("S2");
    repeat (99) tick();
    send_byte("1");
    check_out("timeout.byte_wins", 1'b0, 8'h00, 1'b0, 8'h00);
    send_byte(ASCII_LF);
    check_out("timeout.after", 1'b1, ACK_OK, 1'b0, 8'h04);
    tick();
`else
    do_reset();
    send_str("S2");
    repeat (150) tick();
    check_out("no_timeout.wait", 1'b0, 8'h00, 1'b0, 8'h00);
    send_str("1\n");
    check_out("no_timeout.done", 1'b1, ACK_OK, 1'b0, 8'h04);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
